// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // $clog2(1) is 0, which would give a zero-width index.
  function automatic int unsigned id_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request after i_last, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdW     = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IdW-1:0]     i_last,
  output logic               o_found,
  output logic [IdW-1:0]     o_idx
);

  logic [IdW-1:0] w_pos;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    // Scan farthest first so the nearest position after i_last is the last write.
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      w_pos = IdW'((32'(i_last) + k) % NUM_REQ);
      if (i_req[w_pos]) begin
        o_found = 1'b1;
        o_idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; each grant is one BURST_LEN-word burst,
// admitted only when the FIFO has room, and aborted after IDLE_TIMEOUT producer-idle cycles.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned BURST_LEN    = 4,
  parameter int unsigned IDLE_TIMEOUT = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [DATA_WIDTH-1:0]               fifo_wr_data,
  output logic                                fifo_wr_en,
  input  logic                                fifo_full,
  input  logic                                fifo_almost_full,
  output logic                                busy,
  output logic [id_width(NUM_REQ)-1:0]        grant_id,
  output logic                                timeout_err
);

  localparam int unsigned IdW    = id_width(NUM_REQ);
  localparam int unsigned BeatW  = $clog2(BURST_LEN + 1);
  localparam int unsigned StallW = $clog2(IDLE_TIMEOUT + 1);

  arb_state_e       r_state, w_state_next;
  logic [IdW-1:0]   r_grant, r_last_grant, w_pick_idx;
  logic [BeatW-1:0] r_beat_cnt;
  logic [StallW-1:0] r_stall_cnt;
  logic w_pick_found, w_start, w_g_valid, w_xfer, w_idle, w_last_beat, w_timeout;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IdW     (IdW)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_last  (r_last_grant),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

  assign w_g_valid   = req_valid[r_grant];
  assign w_start     = (r_state == ARB) && w_pick_found && !fifo_almost_full;
  assign w_xfer      = (r_state == BURST) && w_g_valid && !fifo_full;
  // FIFO backpressure is not the producer's fault, so it neither counts nor clears.
  assign w_idle      = (r_state == BURST) && !w_g_valid && !fifo_full;
  assign w_last_beat = w_xfer && (r_beat_cnt == BeatW'(BURST_LEN - 1));
  assign w_timeout   = w_idle && (r_stall_cnt == StallW'(IDLE_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ARB;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ARB:     if (w_start) w_state_next = BURST;
      BURST:   if (w_last_beat || w_timeout) w_state_next = ARB;
      default: w_state_next = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant      <= '0;
      r_last_grant <= IdW'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
      r_stall_cnt  <= '0;
    end else if (w_start) begin
      r_grant     <= w_pick_idx;
      r_beat_cnt  <= '0;
      r_stall_cnt <= '0;
    end else if (w_xfer) begin
      r_beat_cnt  <= r_beat_cnt + BeatW'(1);
      r_stall_cnt <= '0;
      if (w_last_beat) r_last_grant <= r_grant;
    end else if (w_idle) begin
      r_stall_cnt <= r_stall_cnt + StallW'(1);
      if (w_timeout) r_last_grant <= r_grant;
    end
  end

  always_comb begin
    req_ready   = '0;
    fifo_wr_en  = 1'b0;
    busy        = 1'b0;
    timeout_err = 1'b0;
    if (r_state == BURST) begin
      busy               = 1'b1;
      req_ready[r_grant] = !fifo_full;
      fifo_wr_en         = w_xfer;
      timeout_err        = w_timeout;
    end
  end

  always_comb begin
    fifo_wr_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_grant == IdW'(i)) fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign grant_id = r_grant;

endmodule
